// File: rtl/mine_pkg.sv
// rtl/mine_pkg.sv - shared state type, default constants and width helpers for the mining round sequencer
package mine_pkg;

    localparam int SHA_ROUNDS  = 64;
    localparam int NONCE_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } mine_state_e;

    function automatic int ph_w(input int n_phases);
        return (n_phases > 1) ? $clog2(n_phases) : 1;
    endfunction

    function automatic int rd_w(input int n_rounds);
        return (n_rounds > 1) ? $clog2(n_rounds) : 1;
    endfunction

endpackage

// File: rtl/mine_round_sequencer_if.sv
// rtl/mine_round_sequencer_if.sv - work-loader/datapath bundle for the sequencer; hash_count present with MINE_SEQ_PERF_EN
interface mine_round_sequencer_if #(
    parameter int N_PHASES = 4,
    parameter int N_ROUNDS = mine_pkg::SHA_ROUNDS,
    parameter int NONCE_W  = mine_pkg::NONCE_W_DEF
);
    import mine_pkg::*;

    localparam int PH_W = ph_w(N_PHASES);
    localparam int RD_W = rd_w(N_ROUNDS);

    logic               start;
    logic               abort;
    logic               stall;
    logic [NONCE_W-1:0] nonce_start;
    logic [NONCE_W-1:0] nonce_end;
    logic               found;
    logic [PH_W-1:0]    phase;
    logic [RD_W-1:0]    round;
    logic [NONCE_W-1:0] nonce;
    logic               busy;
    logic               hash_done;
    logic               hit;
    logic               finished;
`ifdef MINE_SEQ_PERF_EN
    logic [31:0]        hash_count;
`endif

    modport master (
        output start, abort, stall, nonce_start, nonce_end, found,
`ifdef MINE_SEQ_PERF_EN
        input  hash_count,
`endif
        input  phase, round, nonce, busy, hash_done, hit, finished
    );

    modport slave (
        input  start, abort, stall, nonce_start, nonce_end, found,
`ifdef MINE_SEQ_PERF_EN
        output hash_count,
`endif
        output phase, round, nonce, busy, hash_done, hit, finished
    );

endinterface

// File: rtl/mine_phase_round_ctr.sv
// rtl/mine_phase_round_ctr.sv - nested phase-within-round counter with enable, clear and terminal count
module mine_phase_round_ctr
    import mine_pkg::*;
#(
    parameter int N_PHASES = 4,
    parameter int N_ROUNDS = SHA_ROUNDS,
    parameter int PH_W     = ph_w(N_PHASES),
    parameter int RD_W     = rd_w(N_ROUNDS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    output logic [PH_W-1:0] phase,
    output logic [RD_W-1:0] round,
    output logic            tc
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PHASES - 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(N_ROUNDS - 1);

    assign tc = (phase == PH_LAST) && (round == RD_LAST);

    // Explicit wrap keeps non-power-of-two phase/round counts in range.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= '0;
            round <= '0;
        end else if (clr) begin
            phase <= '0;
            round <= '0;
        end else if (en) begin
            if (phase == PH_LAST) begin
                phase <= '0;
                round <= (round == RD_LAST) ? '0 : round + RD_W'(1);
            end else begin
                phase <= phase + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/mine_round_sequencer.sv
// rtl/mine_round_sequencer.sv - round/phase/nonce sequencer for the mining core; MINE_SEQ_PERF_EN adds hash_count
module mine_round_sequencer
    import mine_pkg::*;
#(
    parameter int N_PHASES = 4,
    parameter int N_ROUNDS = SHA_ROUNDS,
    parameter int NONCE_W  = NONCE_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    mine_round_sequencer_if.slave bus
);

    localparam int PH_W = ph_w(N_PHASES);
    localparam int RD_W = rd_w(N_ROUNDS);

    mine_state_e        state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, end_q;
    logic               hit_q, finished_q;
    logic               hit_d, finished_d;
    logic               load, nonce_inc, hash_done_d;
    logic               ctr_en, ctr_clr, ctr_tc;

    mine_phase_round_ctr #(
        .N_PHASES (N_PHASES),
        .N_ROUNDS (N_ROUNDS),
        .PH_W     (PH_W),
        .RD_W     (RD_W)
    ) u_ctr (
        .clock (clock),
        .reset (reset),
        .en    (ctr_en),
        .clr   (ctr_clr),
        .phase (bus.phase),
        .round (bus.round),
        .tc    (ctr_tc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // abort overrides every state, including a start in IDLE.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        nonce_inc   = 1'b0;
        hash_done_d = 1'b0;
        hit_d       = 1'b0;
        finished_d  = 1'b0;
        ctr_en      = 1'b0;
        ctr_clr     = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            ctr_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        load    = 1'b1;
                        ctr_clr = 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        ctr_en = 1'b1;
                        if (ctr_tc) begin
                            hash_done_d = 1'b1;
                            state_d     = CHECK;
                        end
                    end
                end
                CHECK: begin
                    ctr_clr = 1'b1;
                    if (bus.found) begin
                        hit_d      = 1'b1;
                        finished_d = 1'b1;
                        state_d    = IDLE;
                    end else if (nonce_q == end_q) begin
                        finished_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        nonce_inc = 1'b1;
                        state_d   = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nonce_q    <= '0;
            end_q      <= '0;
            hit_q      <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            hit_q      <= hit_d;
            finished_q <= finished_d;
            if (load) begin
                nonce_q <= bus.nonce_start;
                end_q   <= bus.nonce_end;
            end else if (nonce_inc) begin
                nonce_q <= nonce_q + NONCE_W'(1);
            end
        end
    end

`ifdef MINE_SEQ_PERF_EN
    logic [31:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (state_q == CHECK && !bus.abort && count_q != '1) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.hash_count = count_q;
`endif

    assign bus.nonce     = nonce_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.hash_done = hash_done_d;
    assign bus.hit       = hit_q;
    assign bus.finished  = finished_q;

endmodule

// File: tb/tb_mine_round_sequencer.sv
// tb/tb_mine_round_sequencer.sv - directed bench for mine_round_sequencer (4 phases, 4 rounds, 8-bit nonce); MINE_SEQ_PERF_EN checks hash_count
module tb_mine_round_sequencer;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mine_round_sequencer_if #(.N_PHASES(4), .N_ROUNDS(4), .NONCE_W(8)) bus ();

    mine_round_sequencer #(.N_PHASES(4), .N_ROUNDS(4), .NONCE_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int         hd_t[$];
    logic [7:0] hd_nonce[$];
    int         fin_t, fin_n, hit_n;
    logic       fin_hit, fin_busy;
    logic [7:0] fin_nonce;
    logic [3:0] frz_a, frz_b;
    int         fin_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int hd_at(input int i);
        return (i < hd_t.size()) ? hd_t[i] : -1;
    endfunction

    function automatic logic [31:0] hn_at(input int i);
        return (i < hd_nonce.size()) ? {24'h0, hd_nonce[i]} : 32'hffff_ffff;
    endfunction

    task automatic start_job(input logic [7:0] ns, input logic [7:0] ne);
        bus.nonce_start = ns;
        bus.nonce_end   = ne;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    // t = 0 is the first RUN cycle; found is raised for the CHECK cycle after the found_on-th hash.
    task automatic run_job(input int found_on, input int stall_from, input int stall_len, input int budget);
        logic pend;
        pend = 1'b0;
        hd_t.delete();
        hd_nonce.delete();
        fin_t = -1; fin_n = 0; hit_n = 0;
        fin_hit = 1'b0; fin_busy = 1'b1; fin_nonce = 8'h00;
        frz_a = 4'hf; frz_b = 4'hf;
        for (int t = 0; t < budget; t++) begin
            bus.stall = (t >= stall_from) && (t < stall_from + stall_len);
            bus.found = pend;
            pend = 1'b0;
            #1;
            if (t == stall_from) frz_a = {bus.phase, bus.round};
            if (t == stall_from + stall_len) frz_b = {bus.phase, bus.round};
            if (bus.hash_done) begin
                hd_t.push_back(t);
                hd_nonce.push_back(bus.nonce);
                if (hd_t.size() == found_on) pend = 1'b1;
            end
            if (bus.hit) hit_n++;
            if (bus.finished) begin
                fin_n++;
                if (fin_t < 0) begin
                    fin_t     = t;
                    fin_hit   = bus.hit;
                    fin_nonce = bus.nonce;
                    fin_busy  = bus.busy;
                end
            end
            if (fin_t >= 0 && t > fin_t) break;
            tick();
        end
        bus.stall = 1'b0;
        bus.found = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.stall       = 1'b0;
        bus.found       = 1'b0;
        bus.nonce_start = 8'h00;
        bus.nonce_end   = 8'h00;
        tick();
        tick();
        chk("reset_outputs", {bus.phase, bus.round, bus.nonce, bus.busy, bus.hash_done, bus.hit, bus.finished}, 32'h0);
        reset = 1'b0;
        tick();
        chk("idle_busy", bus.busy, 1'b0);

        // Reset mid-RUN
        start_job(8'h05, 8'h09);
        chk("run_busy", bus.busy, 1'b1);
        chk("run_nonce", bus.nonce, 8'h05);
        tick(); tick(); tick();
        chk("run_phase3", bus.phase, 2'd3);
        reset = 1'b1;
        tick();
        chk("midreset_outputs", {bus.phase, bus.round, bus.nonce, bus.busy, bus.hash_done, bus.hit, bus.finished}, 32'h0);
        reset = 1'b0;
        tick();
        chk("midreset_no_finish", {bus.busy, bus.finished}, 2'b00);

        // Three-nonce range, never found
        start_job(8'h10, 8'h12);
        run_job(0, 1000, 0, 200);
        chk("r3_hd_count", hd_t.size(), 3);
        chk("r3_hd_first", hd_at(0), 15);
        chk("r3_hd_gap1", hd_at(1) - hd_at(0), 17);
        chk("r3_hd_gap2", hd_at(2) - hd_at(1), 17);
        chk("r3_fin_t", fin_t, 51);
        chk("r3_fin_hit", fin_hit, 1'b0);
        chk("r3_fin_nonce", fin_nonce, 8'h12);
        chk("r3_fin_busy", fin_busy, 1'b0);
        chk("r3_fin_once", fin_n, 1);
        chk("r3_hit_none", hit_n, 0);
`ifdef MINE_SEQ_PERF_EN
        chk("r3_hash_count", bus.hash_count, 32'd3);
`endif

        // Hit on second nonce
        start_job(8'h20, 8'h2F);
        run_job(2, 1000, 0, 200);
        chk("hit_hd_count", hd_t.size(), 2);
        chk("hit_fin_t", fin_t, 34);
        chk("hit_fin_hit", fin_hit, 1'b1);
        chk("hit_nonce", fin_nonce, 8'h21);
        chk("hit_busy", fin_busy, 1'b0);
        chk("hit_once", hit_n, 1);
        chk("hit_fin_once", fin_n, 1);

        // Wrapping range FE..01
        start_job(8'hFE, 8'h01);
        run_job(0, 1000, 0, 200);
        chk("wrap_hd_count", hd_t.size(), 4);
        chk("wrap_n0", hn_at(0), 8'hFE);
        chk("wrap_n1", hn_at(1), 8'hFF);
        chk("wrap_n2", hn_at(2), 8'h00);
        chk("wrap_n3", hn_at(3), 8'h01);
        chk("wrap_fin_t", fin_t, 68);
        chk("wrap_fin_nonce", fin_nonce, 8'h01);
        chk("wrap_fin_hit", fin_hit, 1'b0);

        // Stall 5 cycles mid-round
        start_job(8'h30, 8'h30);
        run_job(0, 5, 5, 200);
        chk("stall_frz_start", frz_a, 4'b0101);
        chk("stall_frz_end", frz_b, 4'b0101);
        chk("stall_hd_count", hd_t.size(), 1);
        chk("stall_hd_t", hd_at(0), 20);
        chk("stall_fin_t", fin_t, 22);

        // Stall on the terminal phase suppresses hash_done
        start_job(8'h31, 8'h31);
        run_job(0, 15, 2, 200);
        chk("stall_tc_hd_count", hd_t.size(), 1);
        chk("stall_tc_hd_t", hd_at(0), 17);
        chk("stall_tc_fin_t", fin_t, 19);

        // start while busy ignored, then abort in RUN
        start_job(8'h40, 8'h41);
        tick(); tick();
        bus.nonce_start = 8'h77;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
        chk("busy_start_nonce", bus.nonce, 8'h40);
        chk("busy_start_phase", bus.phase, 2'd3);
        tick(); tick(); tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_phase_round", {bus.phase, bus.round}, 4'b0000);
        chk("abort_nonce", bus.nonce, 8'h40);
        chk("abort_pulses", {bus.hit, bus.finished}, 2'b00);
        fin_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.finished || bus.hit) fin_seen++;
        end
        chk("abort_no_finish", fin_seen, 0);

        // start and abort together in IDLE
        bus.nonce_start = 8'h50;
        bus.nonce_end   = 8'h50;
        bus.start       = 1'b1;
        bus.abort       = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        chk("start_abort_busy", bus.busy, 1'b0);
        chk("start_abort_nonce", bus.nonce, 8'h40);
        tick();
        chk("start_abort_idle", {bus.busy, bus.finished}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mine_round_sequencer.md
Name: mine_round_sequencer

Overview:
Parametrised round/phase sequencer for the SHA-256 mining core; the multi-phase, multi-round successor of the 2-bit mining phase counter.
- Steps a phase counter inside a round counter and iterates a nonce over an inclusive range.
- Samples the comparator's found flag once per hash and stops on a hit or when the range is exhausted.
- Sits between the work-loader (start, nonce range) and the hash datapath (phase, round, nonce).

Parameters:
N_PHASES, 4, clock phases per SHA round (>=2)
N_ROUNDS, 64, rounds per hash (>=2)
NONCE_W, 32, nonce width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a job; accepted in IDLE only
abort  in  1  synchronous return to IDLE
stall  in  1  freeze phase/round in RUN
nonce_start  in  NONCE_W  first nonce, sampled on accepted start
nonce_end  in  NONCE_W  last nonce (inclusive), sampled on accepted start
found  in  1  comparator result, sampled in CHECK only
phase  out  PH_W  current phase; PH_W = clog2(N_PHASES)
round  out  RD_W  current round; RD_W = clog2(N_ROUNDS)
nonce  out  NONCE_W  nonce under evaluation
busy  out  1  high in RUN and CHECK
hash_done  out  1  pulse on last phase of last round, non-stalled cycle
hit  out  1  1-cycle pulse: found in CHECK; nonce holds the winner
finished  out  1  1-cycle pulse on job end (hit or exhausted)

Behaviour:
- Reset: all outputs 0, state IDLE; end register = 0.
- Reset mid-job: job dropped immediately; no finished pulse.
- State IDLE:
  - start & ~abort → RUN; nonce := nonce_start; end := nonce_end; phase = round = 0.
  - abort wins over start in the same cycle.
- State RUN, each cycle with ~stall:
  - phase+1.
  - At phase == N_PHASES-1: phase := 0, round+1.
  - At the last phase of round N_ROUNDS-1: hash_done = 1, → CHECK.
  - stall freezes phase/round; hash_done is never asserted while stalled.
- State CHECK (exactly 1 cycle, ignores stall):
  - found = 1 → hit = 1, finished = 1, → IDLE; nonce held.
  - else nonce == end → finished = 1, → IDLE; nonce held.
  - else nonce := nonce+1 (mod 2^NONCE_W), phase = round = 0, → RUN.
- Range rules:
  - nonce_start > nonce_end is legal: iteration wraps through all-ones to 0.
  - nonce_start == nonce_end evaluates exactly one nonce.
- Latency: N_PHASES*N_ROUNDS + 1 cycles per nonce with no stall.
- start while busy is ignored.
- abort in RUN/CHECK → IDLE next cycle; phase/round cleared; nonce held; no finished/hit pulse.
- hit and finished are registered outputs, asserted the cycle after CHECK evaluates.

Optional Feature:
MINE_SEQ_PERF_EN
- Defined: adds output hash_count [31:0], the number of nonces fully evaluated (incremented in CHECK), cleared on accepted start and on reset, saturating at all-ones.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package mine_pkg holds:
  - the state enum (IDLE, RUN, CHECK);
  - width helpers PH_W and RD_W via clog2;
  - default constants SHA_ROUNDS = 64, NONCE_W_DEF = 32.
- One sub-module, mine_phase_round_ctr: the nested phase/round counter with enable, clear, and terminal-count output. The FSM and nonce logic stay at top level.

Test Plan:
- Bench uses N_PHASES = 4, N_ROUNDS = 4, NONCE_W = 8.
- Reset mid-RUN at nonce 0x05: next cycle all outputs 0, IDLE; a following start is accepted normally.
- start, nonce 0x10..0x12, found never asserted: 3 hash_done pulses 17 cycles apart; finished pulse once, hit = 0; final nonce 0x12.
- start 0x20..0x2F, found = 1 during the second CHECK: hit = finished = 1 together, nonce = 0x21, busy = 0 next cycle.
- Range 0xFE..0x01: nonces visited FE, FF, 00, 01, then finished.
- stall high 5 cycles mid-round: phase/round frozen; hash_done delayed exactly 5 cycles.
- abort during RUN, and start+abort together in IDLE: → IDLE, no finished pulse; simultaneous start ignored.
